// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures period/high time of clk_in in clk cycles, checks lock and errors.
// Define CLK_MON_SYNC_EN to add a 2-flop synchronizer when clk_in comes from another clock domain.
module clk_div_monitor #(
  parameter int unsigned CW       = 8,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TOL      = 0,
  parameter int unsigned ECW      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clk_in,
  input  logic [CW-1:0]  exp_period,
  input  logic           clr_err,
  output logic [CW-1:0]  period,
  output logic [CW-1:0]  high_cnt,
  output logic           period_vld,
  output logic           locked,
  output logic           err,
  output logic [ECW-1:0] err_cnt
);

  localparam int unsigned MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, SEEK, MEAS, LOCKED} state_t;

  state_t        state;
  logic          smp;
  logic          s;
  logic          prev;
  logic [CW-1:0] cnt;
  logic [MW-1:0] match_cnt;
  logic          rise;
  logic          fall;
  logic          in_meas;
  logic          match;
  logic          cmp_en;
  logic          timeout;
  logic          err_evt;
  logic [CW-1:0] diff;

`ifdef CLK_MON_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], clk_in};
  end

  always_comb smp = sync[1];
`else
  always_comb smp = clk_in;
`endif

  always_comb begin
    rise    = s & ~prev;
    fall    = ~s & prev;
    in_meas = (state == MEAS) || (state == LOCKED);
    diff    = (cnt >= exp_period) ? (cnt - exp_period) : (exp_period - cnt);
    match   = (32'(diff) <= TOL);
    cmp_en  = en && in_meas && rise && (exp_period != '0);
    // A saturated counter with no rise means clk_in has stopped toggling.
    timeout = en && in_meas && !rise && (cnt == '1);
    err_evt = (cmp_en && !match) || timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= 1'b0;
      prev       <= 1'b0;
      cnt        <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_cnt   <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      s          <= smp;
      prev       <= s;
      period_vld <= 1'b0;

      if (rise)            cnt <= CW'(1);
      else if (cnt != '1)  cnt <= cnt + CW'(1);

      // Setting wins over clearing, so a clear coinciding with an error leaves a count of one.
      if (err_evt) begin
        err     <= 1'b1;
        err_cnt <= clr_err ? ECW'(1) : ((err_cnt == '1) ? err_cnt : err_cnt + ECW'(1));
      end else if (clr_err) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end

      if (!en) begin
        state     <= IDLE;
        locked    <= 1'b0;
        match_cnt <= '0;
      end else begin
        case (state)
          IDLE: state <= SEEK;
          SEEK: begin
            if (rise) begin
              state     <= MEAS;
              match_cnt <= '0;
            end
          end
          MEAS, LOCKED: begin
            if (timeout) begin
              state     <= SEEK;
              locked    <= 1'b0;
              match_cnt <= '0;
            end else begin
              if (fall) high_cnt <= cnt;
              if (rise) begin
                period     <= cnt;
                period_vld <= 1'b1;
                if (exp_period == '0) begin
                  state     <= MEAS;
                  locked    <= 1'b0;
                  match_cnt <= '0;
                end else if (match) begin
                  if (state == MEAS) begin
                    if (match_cnt == MW'(LOCK_CNT - 1)) begin
                      state     <= LOCKED;
                      locked    <= 1'b1;
                      match_cnt <= MW'(LOCK_CNT);
                    end else begin
                      match_cnt <= match_cnt + MW'(1);
                    end
                  end
                end else begin
                  state     <= MEAS;
                  locked    <= 1'b0;
                  match_cnt <= '0;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: pulse-level reference model feeds a queue, a monitor checks each period_vld.
module tb_clk_div_monitor;

  localparam int unsigned CW       = 8;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned TOL      = 1;
  localparam int unsigned ECW      = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           clk_in;
  logic [CW-1:0]  exp_period;
  logic           clr_err;
  logic [CW-1:0]  period;
  logic [CW-1:0]  high_cnt;
  logic           period_vld;
  logic           locked;
  logic           err;
  logic [ECW-1:0] err_cnt;

  clk_div_monitor #(.CW(CW), .LOCK_CNT(LOCK_CNT), .TOL(TOL), .ECW(ECW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clk_in     (clk_in),
    .exp_period (exp_period),
    .clr_err    (clr_err),
    .period     (period),
    .high_cnt   (high_cnt),
    .period_vld (period_vld),
    .locked     (locked),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned p;
    int unsigned h;
    int unsigned lk;
    int unsigned e;
    int unsigned c;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: pulse shapes, consecutive-match run, error flag/count.
  int unsigned last_h = 0;
  int unsigned last_l = 0;
  int unsigned run    = 0;
  bit          first  = 1'b1;
  int unsigned m_err  = 0;
  int unsigned m_cnt  = 0;

  function automatic void check(input string name, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endfunction

  function automatic void err_event(input bit clr);
    m_err = 1;
    if (clr)              m_cnt = 1;
    else if (m_cnt < 255) m_cnt = m_cnt + 1;
  endfunction

  // Called when a new rise is driven: the previous pulse's period is now complete.
  function automatic void model_rise(input bit clr);
    int unsigned p;
    int unsigned d;
    int unsigned ev;
    bit          evt;
    exp_t        e;
    evt = 1'b0;
    ev  = exp_period;
    if (!first) begin
      p = last_h + last_l;
      if (ev != 0) begin
        d = (p > ev) ? p - ev : ev - p;
        if (d <= TOL) begin
          if (run < LOCK_CNT) run++;
        end else begin
          run = 0;
          evt = 1'b1;
        end
      end else begin
        run = 0;
      end
    end
    if (evt)      err_event(clr);
    else if (clr) begin m_err = 0; m_cnt = 0; end
    if (!first) begin
      e.p  = p;
      e.h  = last_h;
      e.lk = (run >= LOCK_CNT) ? 1 : 0;
      e.e  = m_err;
      e.c  = m_cnt;
      sb.push_back(e);
    end
    first = 1'b0;
  endfunction

  task automatic pulse(input int unsigned h, input int unsigned l, input bit clr = 1'b0);
    for (int unsigned i = 0; i < h; i++) begin
      @(negedge clk);
      clk_in  = 1'b1;
      clr_err = clr && (i == 1);
      if (i == 0) model_rise(clr);
    end
    for (int unsigned i = 0; i < l; i++) begin
      @(negedge clk);
      clk_in  = 1'b0;
      clr_err = 1'b0;
    end
    last_h = h;
    last_l = l;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      clk_in  = 1'b0;
      clr_err = 1'b0;
    end
    last_l = last_l + n;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"},   period,     0);
    check({tag, "_high_cnt"}, high_cnt,   0);
    check({tag, "_vld"},      period_vld, 0);
    check({tag, "_locked"},   locked,     0);
    check({tag, "_err"},      err,        0);
    check({tag, "_err_cnt"},  err_cnt,    0);
  endtask

  // Monitor: every period_vld pulse must match the oldest expected measurement.
  always @(negedge clk) begin
    if (rst_n && period_vld) begin
      if (sb.size() == 0) begin
        check("spurious_vld", period_vld, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("period",   period,   e.p);
        check("high_cnt", high_cnt, e.h);
        check("locked",   locked,   e.lk);
        check("err",      err,      e.e);
        check("err_cnt",  err_cnt,  e.c);
      end
    end
  end

  initial begin
    int unsigned pp;
    int unsigned per;
    int unsigned r;
    int unsigned hh;

    rst_n      = 1'b0;
    en         = 1'b0;
    clk_in     = 1'b0;
    clr_err    = 1'b0;
    exp_period = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    idle(2);

    // Divide-by-2
    exp_period = 8'd2;
    repeat (8) pulse(1, 1);
    idle(4);

    // Divide-by-8 lock, then divide-by-6 mismatch and relock
    exp_period = 8'd8;
    repeat (7) pulse(4, 4);
    repeat (2) pulse(3, 3);
    exp_period = 8'd6;
    repeat (6) pulse(3, 3);
    idle(4);

    // Lock on divide-by-4, then stuck-low timeout, then relock
    exp_period = 8'd4;
    repeat (7) pulse(2, 2);
    pulse(2, 300);
    err_event(1'b0);
    run   = 0;
    first = 1'b1;
    check("timeout_err",     err,     m_err);
    check("timeout_err_cnt", err_cnt, m_cnt);
    check("timeout_locked",  locked,  0);
    repeat (7) pulse(2, 2);

    // Clear coinciding with a mismatch, then clear alone
    pulse(3, 3);
    pulse(2, 2, 1'b1);
    pulse(2, 2);
    idle(3);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    last_l  = last_l + 2;
    m_err   = 0;
    m_cnt   = 0;
    check("clr_err",     err,     0);
    check("clr_err_cnt", err_cnt, 0);

    // Tolerance: 9/11 alternating around exp=10, then a 12-cycle period
    exp_period = 8'd10;
    repeat (4) begin
      pulse(4, 5);
      pulse(5, 6);
    end
    pulse(6, 6);
    pulse(5, 5);
    pulse(5, 5);
    idle(2);

    // Async reset in the middle of a low phase
    exp_period = 8'd4;
    pulse(3, 3);
    pulse(2, 2);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_pending", sb.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    run   = 0;
    first = 1'b1;
    m_err = 0;
    m_cnt = 0;
    idle(2);
    repeat (6) pulse(2, 2);
    idle(2);

    // Enable drop while locked, then restart
    en = 1'b0;
    @(negedge clk);
    last_l = last_l + 1;
    check("en_low_locked",  locked,     0);
    check("en_low_vld",     period_vld, 0);
    check("en_low_err_cnt", err_cnt,    m_cnt);
    idle(3);
    en    = 1'b1;
    run   = 0;
    first = 1'b1;
    idle(2);
    exp_period = 8'd8;
    repeat (6) pulse(3, 5);

    // Randomised blocks; one block runs with comparison disabled
    for (int blk = 0; blk < 6; blk++) begin
      pp         = $urandom_range(14, 3);
      exp_period = (blk == 3) ? 8'd0 : CW'(pp);
      for (int k = 0; k < 8; k++) begin
        r = $urandom_range(9, 0);
        if (r == 0)      per = pp + 3;
        else if (r == 1) per = pp - 1;
        else if (r == 2) per = pp + 1;
        else             per = pp;
        hh = $urandom_range(per - 1, 1);
        pulse(hh, per - hh);
      end
    end
    idle(6);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
